// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - control-unit to wait-state RAM access sequencer with hold
//
// Turns single-cycle read/write strobes from the control unit into timed
// accesses on a synchronous RAM with WAIT_CYCLES wait states, freezing the
// control unit through hold until the access completes.
//
// Parameters:
//   ADDR_W       address width
//   DATA_W       data width
//   WAIT_CYCLES  RAM wait states per access (0..15)
//   ACC_CNT_RST  value acc_cnt takes on reset (0 for normal instances)
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rd_req     memory-read strobe
//   wr_req     memory-write strobe
//   addr       access address
//   wdata      write data
//   rdata      last read data, registered
//   hold       freeze control unit while high
//   mem_en     RAM enable, registered
//   mem_we     RAM write enable, registered, qualified by mem_en
//   mem_addr   RAM address, registered
//   mem_wdata  RAM write data, registered
//   mem_rdata  RAM read data, valid in the last ACCESS cycle
//   err        sticky error: both strobes seen together in IDLE
//   acc_cnt    completed-access counter, wraps
module mem_access_ctrl #(
    parameter int          ADDR_W      = 16,
    parameter int          DATA_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] ACC_CNT_RST = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [15:0]       acc_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       start_acc;
    logic       finish_acc;
    logic       conflict;

    always_comb begin
        state_nxt  = state;
        hold       = 1'b0;
        start_acc  = 1'b0;
        finish_acc = 1'b0;
        conflict   = 1'b0;
        case (state)
            IDLE: begin
                // Combinational so the control unit stalls on the same edge
                // that captures the request.
                hold = rd_req ^ wr_req;
                if (rd_req && wr_req) begin
                    conflict = 1'b1;
                end else if (rd_req ^ wr_req) begin
                    start_acc = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                hold = 1'b1;
                if (cnt == 4'd0) begin
                    finish_acc = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                // One dead cycle lets the control unit advance past the
                // strobe that is still asserted, so it cannot re-trigger.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            hold = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            acc_cnt   <= ACC_CNT_RST;
        end else begin
            state <= state_nxt;
            if (conflict) begin
                err <= 1'b1;
            end
            // mem_we doubles as the latched operation type for the access.
            if (start_acc) begin
                mem_addr  <= addr;
                mem_wdata <= wdata;
                mem_en    <= 1'b1;
                mem_we    <= wr_req;
                cnt       <= WAIT_INIT;
            end
            if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (finish_acc) begin
                if (!mem_we) begin
                    rdata <= mem_rdata;
                end
                mem_en  <= 1'b0;
                mem_we  <= 1'b0;
                acc_cnt <= acc_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Downstream of the multi-cycle control unit.
- Converts its single-cycle memory read/write strobes into timed accesses on the synchronous data/instruction RAM, which has fixed wait states.
- Freezes the control unit through a hold (clock-enable) output until each access completes.
- Returns read data to the data register path.

Parameters:
ADDR_W, 16, address width (AR width)
DATA_W, 8, data width (DR width)
WAIT_CYCLES, 2, RAM wait states per access; legal range 0..15

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rd_req  input  1  memory-read strobe decoded from control-unit signals
wr_req  input  1  memory-write strobe decoded from control-unit signals
addr  input  ADDR_W  access address (from AR)
wdata  input  DATA_W  write data (from DR)
rdata  output  DATA_W  last read data, registered
hold  output  1  freeze control unit (gates its clock enable) while high
mem_en  output  1  RAM enable, registered
mem_we  output  1  RAM write enable, registered; valid only with mem_en
mem_addr  output  ADDR_W  RAM address, registered
mem_wdata  output  DATA_W  RAM write data, registered
mem_rdata  input  DATA_W  RAM read data; valid in last ACCESS cycle
err  output  1  sticky error: rd_req and wr_req high together
acc_cnt  output  16  completed-access counter; wraps at 0xFFFF

Behaviour:
- Reset values (synchronous, priority over everything):
  - state=IDLE.
  - rdata, mem_addr, mem_wdata = 0.
  - mem_en, mem_we, err = 0; acc_cnt=0; internal wait counter=0.
  - hold=0.
- Reset mid-access: next edge returns to IDLE and drops mem_en/mem_we. No rdata update; acc_cnt not incremented.
- States: IDLE, ACCESS, DONE. 2-bit encoding; encoding is implementer's choice.
- IDLE:
  - hold is combinational: hold = (rd_req ^ wr_req).
  - This stops the control unit at the same edge the request is captured.
  - On exactly one request at the edge:
    - mem_addr<=addr; mem_wdata<=wdata; mem_en<=1; mem_we<=wr_req.
    - Latch the op type; cnt<=WAIT_CYCLES; go to ACCESS.
  - rd_req&&wr_req: err<=1 (sticky until rst), no access, hold=0, stay IDLE.
  - Neither request: stay IDLE, hold=0.
- ACCESS:
  - hold=1 (registered).
  - mem_en, mem_we, mem_addr and mem_wdata stable.
  - Input request/addr/wdata changes are ignored; the latched values are used.
  - cnt>0: cnt<=cnt-1.
  - cnt==0:
    - Read: rdata<=mem_rdata.
    - Both read and write: mem_en<=0, mem_we<=0, acc_cnt<=acc_cnt+1, go to DONE.
- DONE:
  - hold=0, so the control unit advances at this edge.
  - Requests are ignored this cycle; this guards against re-triggering on the still-asserted strobe.
  - Next edge goes to IDLE.
- Latency:
  - hold is high for exactly WAIT_CYCLES+2 consecutive cycles per access (1 IDLE-detect + WAIT_CYCLES+1 ACCESS).
  - rdata is valid from the DONE cycle and held until the next completed read.
- WAIT_CYCLES=0: ACCESS lasts one cycle; hold is high for 2 cycles.
- Back-to-back requests:
  - A request seen in the IDLE cycle after DONE starts a new access.
  - Minimum spacing between the starts of two accesses is WAIT_CYCLES+3 cycles.
- Writes never modify rdata.
- acc_cnt wraps from 0xFFFF to 0.

Test Plan:
- Reset, then read with WAIT_CYCLES=2, addr=0x0010, RAM[0x0010]=0xA5 -> mem_en high 3 cycles with mem_we=0; hold high 4 cycles; rdata=0xA5 in DONE; acc_cnt=1.
- Write addr=0x0020, wdata=0x3C -> mem_we=1 for 3 cycles with mem_addr=0x0020, mem_wdata=0x3C; rdata unchanged; acc_cnt increments.
- Hold rd_req high continuously for 20 cycles -> accesses start exactly every 5 cycles (WAIT_CYCLES=2); no start in a DONE cycle.
- rd_req=wr_req=1 in IDLE -> err=1, mem_en stays 0, hold=0; err remains 1 until rst.
- Assert rst in the second ACCESS cycle of a write -> next edge: mem_en=0, state IDLE, acc_cnt and rdata unchanged.
- Instance with WAIT_CYCLES=0, read 0x0000 holding 0x7E -> hold high 2 cycles; rdata=0x7E; preset acc_cnt=0xFFFF -> wraps to 0x0000.
